// File: rtl/wb_openram_banked_bridge_pkg.sv
// Shared types and helpers for the banked Wishbone-to-OpenRAM bridge.
package wb_openram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK
  } port_st_e;

  localparam logic [31:0] ERR_PATTERN_DEF = 32'hDEAD_BEEF;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bank-select field width; a single bank still owns one address bit.
  function automatic int bank_sel_w(input int nb);
    return (clog2(nb) < 1) ? 1 : clog2(nb);
  endfunction

endpackage

// File: rtl/wb_openram_banked_bridge_if.sv
// Wishbone slave-side bus bundle. The read-only modport drops the write path.
interface wb_openram_banked_bridge_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        ack;
  logic [31:0] dat_r;

  modport master   (output stb, cyc, we, sel, adr, dat_w, input ack, dat_r);
  modport slave    (input stb, cyc, we, sel, adr, dat_w, output ack, dat_r);
  modport slave_ro (input stb, cyc, adr, output ack, dat_r);
endinterface

// File: rtl/wb_openram_banked_bridge_port_fsm.sv
// One Wishbone port: samples a decoded request in IDLE, drives one macro
// port for a single ACCESS cycle, waits out the read latency, acks once.
module wb_openram_port_fsm
  import wb_openram_pkg::*;
#(
  parameter bit          READ_ONLY    = 1'b0,
  parameter int          NUM_BANKS    = 2,
  parameter int          BANK_ADDR_W  = 8,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ERR_PATTERN  = ERR_PATTERN_DEF,
  localparam int         BSW          = bank_sel_w(NUM_BANKS)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   req_i,
  input  logic                   stall_i,
  input  logic                   we_i,
  input  logic                   blocked_i,
  input  logic                   in_range_i,
  input  logic [BSW-1:0]         bank_i,
  input  logic [BANK_ADDR_W-1:0] word_i,
  input  logic [3:0]             sel_i,
  input  logic [31:0]            din_i,
  input  logic [31:0]            rdata_i,
  output logic                   start_o,
  output logic [BSW-1:0]         bank_o,
  output logic [NUM_BANKS-1:0]   csb_o,
  output logic                   web_o,
  output logic [3:0]             wmask_o,
  output logic [BANK_ADDR_W-1:0] addr_o,
  output logic [31:0]            din_o,
  output logic                   ack_o,
  output logic [31:0]            dat_o
);

  port_st_e               state_q;
  logic [1:0]             cnt_q;
  logic                   rd_q, err_q;
  logic [BSW-1:0]         bank_q;
  logic [NUM_BANKS-1:0]   csb_q;
  logic                   web_q, ack_q;
  logic [3:0]             wmask_q;
  logic [BANK_ADDR_W-1:0] addr_q;
  logic [31:0]            din_q, dat_q;

  logic                 wr, go;
  logic [NUM_BANKS-1:0] bank_oh;

  assign wr      = READ_ONLY ? 1'b0 : we_i;
  // A blocked write still takes the normal ack path, it just never selects a macro.
  assign go      = in_range_i && !(wr && blocked_i);
  assign start_o = (state_q == ST_IDLE) && req_i && !stall_i;

  // One-hot chip-select pattern for the requested bank.
  always_comb begin
    bank_oh = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_oh[b] = (bank_i == BSW'(b));
    end
  end

  // Port FSM with all macro-side and bus-side outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      bank_q  <= '0;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_o) begin
            state_q <= ST_ACCESS;
            rd_q    <= !wr;
            err_q   <= !in_range_i;
            bank_q  <= bank_i;
            addr_q  <= word_i;
            wmask_q <= sel_i;
            din_q   <= din_i;
            csb_q   <= go ? ~bank_oh : '1;
            web_q   <= !(wr && go);
          end
        end
        ST_ACCESS: begin
          csb_q <= '1;
          web_q <= 1'b1;
          if (rd_q && !err_q) begin
            state_q <= ST_WAIT;
            cnt_q   <= 2'(READ_LATENCY - 1);
          end else begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            if (rd_q) dat_q <= ERR_PATTERN;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dat_q   <= rdata_i;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_ACK: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bank_o  = bank_q;
  assign csb_o   = csb_q;
  assign web_o   = web_q;
  assign wmask_o = wmask_q;
  assign addr_o  = addr_q;
  assign din_o   = din_q;
  assign ack_o   = ack_q;
  assign dat_o   = dat_q;

endmodule

// File: rtl/wb_openram_banked_bridge.sv
// Maps NUM_BANKS 1rw1r OpenRAM macros into one Wishbone window.
// WB0 is read/write on macro port 0, WB1 is read-only on macro port 1.
module wb_openram_banked_bridge
  import wb_openram_pkg::*;
#(
  parameter int          NUM_BANKS    = 2,
  parameter int          BANK_ADDR_W  = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ERR_PATTERN  = ERR_PATTERN_DEF,
  localparam int         BSW          = bank_sel_w(NUM_BANKS),
  localparam int         HI           = 2 + BANK_ADDR_W + BSW
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       writable_i,
  wb_openram_banked_bridge_if.slave    wbs0,
  wb_openram_banked_bridge_if.slave_ro wbs1,
  output logic [NUM_BANKS-1:0]       ram_clk0_o,
  output logic [NUM_BANKS-1:0]       ram_clk1_o,
  output logic [NUM_BANKS-1:0]       ram_csb0_o,
  output logic [NUM_BANKS-1:0]       ram_csb1_o,
  output logic                       ram_web0_o,
  output logic [3:0]                 ram_wmask0_o,
  output logic [BANK_ADDR_W-1:0]     ram_addr0_o,
  output logic [BANK_ADDR_W-1:0]     ram_addr1_o,
  output logic [31:0]                ram_din0_o,
  input  logic [32*NUM_BANKS-1:0]    ram_dout0_i,
  input  logic [32*NUM_BANKS-1:0]    ram_dout1_i,
  output logic [1:0]                 status_o
);

  logic [BANK_ADDR_W-1:0] word0, word1;
  logic [BSW-1:0]         bank0, bank1, bank0_q, bank1_q;
  logic                   rng0, rng1, start0, start1, coll;
  logic [31:0]            rdata0, rdata1;
  logic [1:0]             status_d, status_q;

  logic                   unused_adr, unused_web1;
  logic [3:0]             unused_wmask1;
  logic [31:0]            unused_din1;

  assign unused_adr = ^{wbs0.adr[1:0], wbs1.adr[1:0]};

  assign ram_clk0_o = {NUM_BANKS{wb_clk_i}};
  assign ram_clk1_o = {NUM_BANKS{wb_clk_i}};

  assign word0 = wbs0.adr[2 +: BANK_ADDR_W];
  assign word1 = wbs1.adr[2 +: BANK_ADDR_W];
  assign bank0 = wbs0.adr[2 + BANK_ADDR_W +: BSW];
  assign bank1 = wbs1.adr[2 + BANK_ADDR_W +: BSW];
  assign rng0  = (wbs0.adr[31:HI] == BASE_ADDR[31:HI]) && (int'(bank0) < NUM_BANKS);
  assign rng1  = (wbs1.adr[31:HI] == BASE_ADDR[31:HI]) && (int'(bank1) < NUM_BANKS);

  // WB1 is held one cycle when it would read the word WB0 is writing in the
  // same ACCESS cycle; it then reads after the write edge and sees new data.
  assign coll = start0 && wbs0.we && rng0 && writable_i && rng1 &&
                (bank0 == bank1) && (word0 == word1);

  // Read-data bank mux keyed by each port's registered bank.
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank0_q == BSW'(b)) rdata0 = ram_dout0_i[32*b +: 32];
      if (bank1_q == BSW'(b)) rdata1 = ram_dout1_i[32*b +: 32];
    end
  end

  wb_openram_port_fsm #(
    .READ_ONLY(1'b0), .NUM_BANKS(NUM_BANKS), .BANK_ADDR_W(BANK_ADDR_W),
    .READ_LATENCY(READ_LATENCY), .ERR_PATTERN(ERR_PATTERN)
  ) u_p0 (
    .clk_i(wb_clk_i), .rst_n_i(wb_rst_n_i),
    .req_i(wbs0.stb & wbs0.cyc), .stall_i(1'b0), .we_i(wbs0.we),
    .blocked_i(!writable_i), .in_range_i(rng0), .bank_i(bank0), .word_i(word0),
    .sel_i(wbs0.sel), .din_i(wbs0.dat_w), .rdata_i(rdata0),
    .start_o(start0), .bank_o(bank0_q), .csb_o(ram_csb0_o), .web_o(ram_web0_o),
    .wmask_o(ram_wmask0_o), .addr_o(ram_addr0_o), .din_o(ram_din0_o),
    .ack_o(wbs0.ack), .dat_o(wbs0.dat_r)
  );

  wb_openram_port_fsm #(
    .READ_ONLY(1'b1), .NUM_BANKS(NUM_BANKS), .BANK_ADDR_W(BANK_ADDR_W),
    .READ_LATENCY(READ_LATENCY), .ERR_PATTERN(ERR_PATTERN)
  ) u_p1 (
    .clk_i(wb_clk_i), .rst_n_i(wb_rst_n_i),
    .req_i(wbs1.stb & wbs1.cyc), .stall_i(coll), .we_i(1'b0),
    .blocked_i(1'b0), .in_range_i(rng1), .bank_i(bank1), .word_i(word1),
    .sel_i(4'h0), .din_i(32'h0), .rdata_i(rdata1),
    .start_o(start1), .bank_o(bank1_q), .csb_o(ram_csb1_o), .web_o(unused_web1),
    .wmask_o(unused_wmask1), .addr_o(ram_addr1_o), .din_o(unused_din1),
    .ack_o(wbs1.ack), .dat_o(wbs1.dat_r)
  );

  // Sticky error flags, set on request acceptance.
  always_comb begin
    status_d = status_q;
    if (start0 && wbs0.we && rng0 && !writable_i) status_d[0] = 1'b1;
    if ((start0 && !rng0) || (start1 && !rng1))   status_d[1] = 1'b1;
  end

  // Status register, cleared only by reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) status_q <= '0;
    else             status_q <= status_d;
  end

  assign status_o = status_q;

endmodule

// File: tb/tb_wb_openram_banked_bridge.sv
// Directed bench: two bridges (read latency 1 and 3) with behavioural macros.
module tb_wb_openram_banked_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, writable;

  // Port index p: 0 = dut0 WB0, 1 = dut0 WB1, 2 = dut1 WB0, 3 = dut1 WB1.
  logic        w_stb [4];
  logic        w_we  [4];
  logic [3:0]  w_sel [4];
  logic [31:0] w_adr [4];
  logic [31:0] w_dat [4];
  logic        w_ack [4];
  logic [31:0] w_rd  [4];

  wb_openram_banked_bridge_if ifs [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign ifs[g].stb   = w_stb[g];
    assign ifs[g].cyc   = w_stb[g];
    assign ifs[g].we    = w_we[g];
    assign ifs[g].sel   = w_sel[g];
    assign ifs[g].adr   = w_adr[g];
    assign ifs[g].dat_w = w_dat[g];
    assign w_ack[g]     = ifs[g].ack;
    assign w_rd[g]      = ifs[g].dat_r;
  end

  logic [1:0]  clk0 [2], clk1 [2], csb0 [2], csb1 [2], status [2];
  logic        web0 [2];
  logic [3:0]  wmask0 [2];
  logic [7:0]  addr0 [2], addr1 [2];
  logic [31:0] din0 [2];
  logic [63:0] dout0 [2], dout1 [2];

  wb_openram_banked_bridge #(.READ_LATENCY(1)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .writable_i(writable),
    .wbs0(ifs[0]), .wbs1(ifs[1]),
    .ram_clk0_o(clk0[0]), .ram_clk1_o(clk1[0]), .ram_csb0_o(csb0[0]), .ram_csb1_o(csb1[0]),
    .ram_web0_o(web0[0]), .ram_wmask0_o(wmask0[0]), .ram_addr0_o(addr0[0]),
    .ram_addr1_o(addr1[0]), .ram_din0_o(din0[0]), .ram_dout0_i(dout0[0]),
    .ram_dout1_i(dout1[0]), .status_o(status[0])
  );

  wb_openram_banked_bridge #(.READ_LATENCY(3)) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .writable_i(writable),
    .wbs0(ifs[2]), .wbs1(ifs[3]),
    .ram_clk0_o(clk0[1]), .ram_clk1_o(clk1[1]), .ram_csb0_o(csb0[1]), .ram_csb1_o(csb1[1]),
    .ram_web0_o(web0[1]), .ram_wmask0_o(wmask0[1]), .ram_addr0_o(addr0[1]),
    .ram_addr1_o(addr1[1]), .ram_din0_o(din0[1]), .ram_dout0_i(dout0[1]),
    .ram_dout1_i(dout1[1]), .status_o(status[1])
  );

  // Behavioural 1rw1r macros; read data appears RL edges after capture.
  for (genvar g = 0; g < 2; g++) begin : g_mac
    localparam int RL = (g == 0) ? 1 : 3;
    logic [31:0] mem [2][256];
    logic [31:0] q0 [2][3];
    logic [31:0] q1 [2][3];
    always @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
        if (!csb0[g][b]) begin
          if (!web0[g]) begin
            for (int i = 0; i < 4; i++)
              if (wmask0[g][i]) mem[b][addr0[g]][8*i +: 8] <= din0[g][8*i +: 8];
          end else begin
            q0[b][0] <= mem[b][addr0[g]];
          end
        end
        if (!csb1[g][b]) q1[b][0] <= mem[b][addr1[g]];
        for (int k = 1; k < 3; k++) begin
          q0[b][k] <= q0[b][k-1];
          q1[b][k] <= q1[b][k-1];
        end
      end
    end
    assign dout0[g] = {q0[1][RL-1], q0[0][RL-1]};
    assign dout1[g] = {q1[1][RL-1], q1[0][RL-1]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic req(input int p, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    w_stb[p] = 1'b1;
    w_we[p]  = we;
    w_adr[p] = adr;
    w_dat[p] = dat;
    w_sel[p] = sel;
  endtask

  // Waits for ack (k = cycles after request cycle), records csb at k=1 and
  // how many cycles the port's csb was active, drops stb, checks 1-cycle ack.
  task automatic wait_ack(input int p, output int lat, output logic [31:0] d,
                          output logic [1:0] cs1, output int lows);
    logic [1:0] cs;
    lat  = -1;
    d    = '0;
    cs1  = 2'b11;
    lows = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cs = p[0] ? csb1[p/2] : csb0[p/2];
      if (k == 1) cs1 = cs;
      if (cs != 2'b11) lows++;
      if (w_ack[p]) begin
        lat = k;
        d   = w_rd[p];
        break;
      end
    end
    @(posedge clk);
    #1 w_stb[p] = 1'b0;
    @(negedge clk);
    chk($sformatf("p%0d ack_one_cycle", p), 32'(w_ack[p]), 32'd0);
  endtask

  task automatic xfer(input int p, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output int lat, output logic [31:0] d,
                      output logic [1:0] cs1, output int lows);
    @(posedge clk);
    #1 req(p, we, adr, dat, sel);
    wait_ack(p, lat, d, cs1, lows);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat1, lows, lows1, nack;
    logic [31:0] d, d1;
    logic [1:0]  cs1, cs1b;

    for (int p = 0; p < 4; p++) begin
      w_stb[p] = 1'b0; w_we[p] = 1'b0; w_sel[p] = 4'h0;
      w_adr[p] = '0;   w_dat[p] = '0;
    end
    rst_n    = 1'b0;
    writable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst csb0",   32'(csb0[0]),   32'h3);
    chk("rst csb1",   32'(csb1[0]),   32'h3);
    chk("rst web0",   32'(web0[0]),   32'h1);
    chk("rst ack0",   32'(w_ack[0]),  32'h0);
    chk("rst ack1",   32'(w_ack[1]),  32'h0);
    chk("rst dat0",   w_rd[0],        32'h0);
    chk("rst addr0",  32'(addr0[0]),  32'h0);
    chk("rst din0",   din0[0],        32'h0);
    chk("rst wmask0", 32'(wmask0[0]), 32'h0);
    chk("rst status", 32'(status[0]), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain write then reads at latency 1 and 3.
    xfer(0, 1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, lat, d, cs1, lows);
    chk("t1 lat",   32'(lat),       32'd2);
    chk("t1 csb",   32'(cs1),       32'h2);
    chk("t1 lows",  32'(lows),      32'd1);
    chk("t1 addr",  32'(addr0[0]),  32'd4);
    chk("t1 wmask", 32'(wmask0[0]), 32'hF);
    xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("t2 lat",   32'(lat), 32'd3);
    chk("t2 dat",   d,        32'h1234_5678);
    xfer(2, 1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, lat, d, cs1, lows);
    chk("t2 rl3 wlat", 32'(lat), 32'd2);
    xfer(2, 1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("t2 rl3 lat",  32'(lat), 32'd5);
    chk("t2 rl3 dat",  d,        32'h1234_5678);

    // Write protection on bank 1 word 1.
    xfer(0, 1'b1, 32'h3000_0404, 32'hCAFE_F00D, 4'hF, lat, d, cs1, lows);
    chk("t3 pre csb", 32'(cs1), 32'h1);
    writable = 1'b0;
    xfer(0, 1'b1, 32'h3000_0404, 32'h1111_1111, 4'hF, lat, d, cs1, lows);
    chk("t3 lat",    32'(lat),       32'd2);
    chk("t3 lows",   32'(lows),      32'd0);
    chk("t3 status", 32'(status[0]), 32'h1);
    writable = 1'b1;
    xfer(0, 1'b0, 32'h3000_0404, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("t3 old",    d, 32'hCAFE_F00D);

    // Out of range: bank 2 on WB0, foreign window on WB1.
    xfer(0, 1'b0, 32'h3000_0800, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("t4 lat",    32'(lat),       32'd2);
    chk("t4 dat",    d,              32'hDEAD_BEEF);
    chk("t4 lows",   32'(lows),      32'd0);
    chk("t4 status", 32'(status[0]), 32'h3);
    xfer(1, 1'b0, 32'h3100_0000, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("t4 wb1 lat", 32'(lat), 32'd2);
    chk("t4 wb1 dat", d,        32'hDEAD_BEEF);

    // Byte-masked write merges with existing data.
    xfer(0, 1'b1, 32'h3000_0010, 32'hAABB_CCDD, 4'b0101, lat, d, cs1, lows);
    xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("mask dat", d, 32'h12BB_56DD);

    // Same-word collision: WB1 slips one cycle and returns new data.
    @(posedge clk);
    #1;
    req(0, 1'b1, 32'h3000_001C, 32'hAAAA_5555, 4'hF);
    req(1, 1'b0, 32'h3000_001C, 32'h0, 4'hF);
    fork
      wait_ack(0, lat, d, cs1, lows);
      wait_ack(1, lat1, d1, cs1b, lows1);
    join
    chk("t5 wb0 lat", 32'(lat),  32'd2);
    chk("t5 wb1 lat", 32'(lat1), 32'd4);
    chk("t5 wb1 dat", d1,        32'hAAAA_5555);

    // Different word in the same cycle: no stall.
    @(posedge clk);
    #1;
    req(0, 1'b1, 32'h3000_0020, 32'h0BAD_0BAD, 4'hF);
    req(1, 1'b0, 32'h3000_001C, 32'h0, 4'hF);
    fork
      wait_ack(0, lat, d, cs1, lows);
      wait_ack(1, lat1, d1, cs1b, lows1);
    join
    chk("nc wb1 lat", 32'(lat1), 32'd3);
    chk("nc wb1 dat", d1,        32'hAAAA_5555);

    // Reset during WB1 WAIT aborts with no ack and clears status.
    chk("t6 status pre", 32'(status[0]), 32'h3);
    @(posedge clk);
    #1 req(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    w_stb[1] = 1'b0;
    nack     = 0;
    @(negedge clk);
    chk("t6 csb1",   32'(csb1[0]),   32'h3);
    chk("t6 csb0",   32'(csb0[0]),   32'h3);
    chk("t6 ack1",   32'(w_ack[1]),  32'h0);
    chk("t6 status", 32'(status[0]), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (w_ack[1]) nack++;
    end
    chk("t6 no ack", 32'(nack), 32'd0);
    xfer(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, d, cs1, lows);
    chk("t6 post lat", 32'(lat), 32'd3);
    chk("t6 post dat", d,        32'h12BB_56DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
